// File: rtl/pipeline_pkg.sv
// Shared decode definitions: opcode encodings, instruction field positions, FSM state type.
// Latency: n/a (declarations and a pure helper function only).
// Backpressure: n/a.
package pipeline_pkg;

    localparam int DATA_W = 16;
    localparam int OPC_W  = 5;
    localparam int REG_W  = 3;
    localparam int FUNC_W = 5;

    // Field bit positions within a 16-bit instruction word
    localparam int OPC_MSB  = 15;
    localparam int OPC_LSB  = 11;
    localparam int SRC_MSB  = 10;
    localparam int SRC_LSB  = 8;
    localparam int DST_MSB  = 7;
    localparam int DST_LSB  = 5;
    localparam int FUNC_MSB = 4;
    localparam int FUNC_LSB = 0;

    localparam logic [OPC_W-1:0] OPC_NOP = 5'd0;
    localparam logic [OPC_W-1:0] OPC_INT = 5'd8;
    localparam logic [OPC_W-1:0] OPC_POP = 5'd9;
    localparam logic [OPC_W-1:0] OPC_LDD = 5'd10;
    localparam logic [OPC_W-1:0] OPC_LDM = 5'd12;
    localparam logic [OPC_W-1:0] OPC_SHL = 5'd13;
    localparam logic [OPC_W-1:0] OPC_SHR = 5'd14;

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_WAIT_IMM = 1'b1
    } dec_state_e;

    // Opcodes whose immediate arrives as the following fetched word
    function automatic logic is_two_word(input logic [OPC_W-1:0] opc);
        return (opc == OPC_LDM) || (opc == OPC_SHL) || (opc == OPC_SHR);
    endfunction

endpackage

// File: rtl/inst_field_extract.sv
// Splits an instruction word into opcode / src / dst / func fields.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no state.
//   word_i     : instruction word
//   opcode_o   : word[15:11]   src_reg_o : word[10:8]
//   dst_reg_o  : word[7:5]     func_o    : word[4:0]
module inst_field_extract
    import pipeline_pkg::*;
(
    input  logic [DATA_W-1:0] word_i,
    output logic [OPC_W-1:0]  opcode_o,
    output logic [REG_W-1:0]  src_reg_o,
    output logic [REG_W-1:0]  dst_reg_o,
    output logic [FUNC_W-1:0] func_o
);

    assign opcode_o  = word_i[OPC_MSB:OPC_LSB];
    assign src_reg_o = word_i[SRC_MSB:SRC_LSB];
    assign dst_reg_o = word_i[DST_MSB:DST_LSB];
    assign func_o    = word_i[FUNC_MSB:FUNC_LSB];

endmodule

// File: rtl/decode_stage.sv
// IF/ID decode stage: registers fetched words, splits fields, merges opcode+immediate pairs.
// Latency: one cycle for one-word ops; two-word ops are valid on the edge accepting the immediate.
// Backpressure: stall freezes all state and outputs (input not consumed); flush kills the op.
//   clk, rst          : clock, synchronous active-high reset
//   inst_in/_valid    : fetched word (0 = bubble) and its qualifier
//   stall, flush      : hold / kill requests from hazard and branch logic
//   opcode..imm       : registered decoded fields; dec_valid qualifies them
//   imm_pending       : first word of a two-word op is held, immediate awaited
module decode_stage
    import pipeline_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] inst_in,
    input  logic              inst_valid,
    input  logic              stall,
    input  logic              flush,
    output logic [OPC_W-1:0]  opcode,
    output logic [REG_W-1:0]  src_reg,
    output logic [REG_W-1:0]  dst_reg,
    output logic [FUNC_W-1:0] func,
    output logic [DATA_W-1:0] imm,
    output logic              dec_valid,
    output logic              imm_pending
);

    dec_state_e        state_q, state_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [OPC_W-1:0]  opcode_q, opcode_d;
    logic [REG_W-1:0]  src_q, src_d;
    logic [REG_W-1:0]  dst_q, dst_d;
    logic [FUNC_W-1:0] func_q, func_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic              dec_valid_q, dec_valid_d;
    logic              imm_pending_q, imm_pending_d;

    // Field views of the incoming word and of the held first word
    logic [OPC_W-1:0]  in_opc, hd_opc;
    logic [REG_W-1:0]  in_src, hd_src;
    logic [REG_W-1:0]  in_dst, hd_dst;
    logic [FUNC_W-1:0] in_func, hd_func;

    inst_field_extract u_in_fields (
        .word_i    (inst_in),
        .opcode_o  (in_opc),
        .src_reg_o (in_src),
        .dst_reg_o (in_dst),
        .func_o    (in_func)
    );

    inst_field_extract u_hold_fields (
        .word_i    (hold_q),
        .opcode_o  (hd_opc),
        .src_reg_o (hd_src),
        .dst_reg_o (hd_dst),
        .func_o    (hd_func)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            hold_q        <= '0;
            opcode_q      <= '0;
            src_q         <= '0;
            dst_q         <= '0;
            func_q        <= '0;
            imm_q         <= '0;
            dec_valid_q   <= 1'b0;
            imm_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            opcode_q      <= opcode_d;
            src_q         <= src_d;
            dst_q         <= dst_d;
            func_q        <= func_d;
            imm_q         <= imm_d;
            dec_valid_q   <= dec_valid_d;
            imm_pending_q <= imm_pending_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        opcode_d    = opcode_q;
        src_d       = src_q;
        dst_d       = dst_q;
        func_d      = func_q;
        imm_d       = imm_q;
        dec_valid_d = dec_valid_q;

        if (flush) begin
            // Flush wins over stall; decoded fields are left as-is, only validity is killed
            state_d     = S_IDLE;
            hold_d      = '0;
            dec_valid_d = 1'b0;
        end else if (!stall) begin
            unique case (state_q)
                S_IDLE: begin
                    dec_valid_d = 1'b0;
                    if (inst_valid && (inst_in != '0)) begin
                        if (is_two_word(in_opc)) begin
                            hold_d  = inst_in;
                            state_d = S_WAIT_IMM;
                        end else begin
                            opcode_d    = in_opc;
                            src_d       = in_src;
                            dst_d       = in_dst;
                            func_d      = in_func;
                            imm_d       = '0;
                            dec_valid_d = 1'b1;
                        end
                    end
                end
                S_WAIT_IMM: begin
                    dec_valid_d = 1'b0;
                    // The immediate may legitimately be zero, so no bubble test here
                    if (inst_valid) begin
                        opcode_d    = hd_opc;
                        src_d       = hd_src;
                        dst_d       = hd_dst;
                        func_d      = hd_func;
                        imm_d       = inst_in;
                        dec_valid_d = 1'b1;
                        hold_d      = '0;
                        state_d     = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        imm_pending_d = (state_d == S_WAIT_IMM);
    end

    assign opcode      = opcode_q;
    assign src_reg     = src_q;
    assign dst_reg     = dst_q;
    assign func        = func_q;
    assign imm         = imm_q;
    assign dec_valid   = dec_valid_q;
    assign imm_pending = imm_pending_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with hand-decoded expected fields.
// Latency: n/a.
// Backpressure: n/a.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] inst_in;
    logic        inst_valid;
    logic        stall;
    logic        flush;
    logic [4:0]  opcode;
    logic [2:0]  src_reg;
    logic [2:0]  dst_reg;
    logic [4:0]  func;
    logic [15:0] imm;
    logic        dec_valid;
    logic        imm_pending;

    int n_checks = 0;
    int n_errors = 0;

    decode_stage dut (
        .clk         (clk),
        .rst         (rst),
        .inst_in     (inst_in),
        .inst_valid  (inst_valid),
        .stall       (stall),
        .flush       (flush),
        .opcode      (opcode),
        .src_reg     (src_reg),
        .dst_reg     (dst_reg),
        .func        (func),
        .imm         (imm),
        .dec_valid   (dec_valid),
        .imm_pending (imm_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the rising edge
    task automatic step(input logic r, input logic v, input logic [15:0] w,
                        input logic s, input logic f);
        rst        = r;
        inst_valid = v;
        inst_in    = w;
        stall      = s;
        flush      = f;
        @(posedge clk);
        #1;
    endtask

    // Check a full decoded op
    task automatic chk_op(input string tag, input logic [4:0] o, input logic [2:0] sr,
                          input logic [2:0] dr, input logic [4:0] fn, input logic [15:0] im,
                          input logic v, input logic p);
        chk({tag, ".opcode"},  32'(opcode),      32'(o));
        chk({tag, ".src"},     32'(src_reg),     32'(sr));
        chk({tag, ".dst"},     32'(dst_reg),     32'(dr));
        chk({tag, ".func"},    32'(func),        32'(fn));
        chk({tag, ".imm"},     32'(imm),         32'(im));
        chk({tag, ".valid"},   32'(dec_valid),   32'(v));
        chk({tag, ".pending"}, 32'(imm_pending), 32'(p));
    endtask

    initial begin
        rst = 1'b1; inst_valid = 1'b0; inst_in = '0; stall = 1'b0; flush = 1'b0;

        // Reset for two cycles, with a word presented that must be ignored
        step(1, 1, 16'h2A65, 0, 0);
        step(1, 1, 16'h2A65, 0, 0);
        chk_op("reset", 5'd0, 3'd0, 3'd0, 5'd0, 16'h0, 1'b0, 1'b0);

        // One-word op: 0x2A65 -> opc 5, src 2, dst 3, func 5
        step(0, 1, 16'h2A65, 0, 0);
        chk_op("oneword", 5'd5, 3'd2, 3'd3, 5'd5, 16'h0, 1'b1, 1'b0);

        // LDM 0x6120 then imm 0x00FF
        step(0, 1, 16'h6120, 0, 0);
        chk("ldm.e1.valid",   32'(dec_valid),   32'd0);
        chk("ldm.e1.pending", 32'(imm_pending), 32'd1);
        step(0, 1, 16'h00FF, 0, 0);
        chk_op("ldm.e2", 5'd12, 3'd1, 3'd1, 5'd0, 16'h00FF, 1'b1, 1'b0);

        // Bubble word: invalid slot, fields keep LDM decode
        step(0, 1, 16'h0000, 0, 0);
        chk_op("bubble", 5'd12, 3'd1, 3'd1, 5'd0, 16'h00FF, 1'b0, 1'b0);

        // inst_valid low with a non-zero word is also no op
        step(0, 0, 16'h2A65, 0, 0);
        chk("novalid.valid", 32'(dec_valid), 32'd0);
        chk("novalid.opc",   32'(opcode),    32'd12);

        // Stall for three cycles holds the 0x2A65 decode
        step(0, 1, 16'h2A65, 0, 0);
        chk("prestall.valid", 32'(dec_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 16'h1111, 1, 0);
            chk_op($sformatf("stall%0d", i), 5'd5, 3'd2, 3'd3, 5'd5, 16'h0, 1'b1, 1'b0);
        end
        // Re-presented 0x1111 -> opc 2, src 1, dst 0, func 17
        step(0, 1, 16'h1111, 0, 0);
        chk_op("poststall", 5'd2, 3'd1, 3'd0, 5'd17, 16'h0, 1'b1, 1'b0);

        // Stall while waiting for the immediate
        step(0, 1, 16'h6120, 0, 0);
        step(0, 1, 16'h00FF, 1, 0);
        chk("wstall.pending", 32'(imm_pending), 32'd1);
        chk("wstall.valid",   32'(dec_valid),   32'd0);
        step(0, 1, 16'h00FF, 0, 0);
        chk_op("wstall.done", 5'd12, 3'd1, 3'd1, 5'd0, 16'h00FF, 1'b1, 1'b0);

        // Flush drops the half-assembled LDM
        step(0, 1, 16'h6120, 0, 0);
        step(0, 1, 16'h00FF, 0, 1);
        chk("flush.valid",   32'(dec_valid),   32'd0);
        chk("flush.pending", 32'(imm_pending), 32'd0);
        step(0, 1, 16'h2A65, 0, 0);
        chk_op("flush.next", 5'd5, 3'd2, 3'd3, 5'd5, 16'h0, 1'b1, 1'b0);

        // Flush wins over a simultaneous stall
        step(0, 1, 16'h2A65, 1, 1);
        chk("flushstall.valid", 32'(dec_valid), 32'd0);
        step(0, 1, 16'h6120, 0, 0);
        step(0, 1, 16'h00FF, 1, 1);
        chk("flushstall.pending", 32'(imm_pending), 32'd0);

        // SHR 0x7000, two idle cycles, then imm 4
        step(0, 1, 16'h7000, 0, 0);
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 16'h0000, 0, 0);
            chk($sformatf("gap%0d.pending", i), 32'(imm_pending), 32'd1);
            chk($sformatf("gap%0d.valid", i),   32'(dec_valid),   32'd0);
        end
        step(0, 1, 16'h0004, 0, 0);
        chk_op("shr", 5'd14, 3'd0, 3'd0, 5'd0, 16'h0004, 1'b1, 1'b0);

        // A zero immediate is accepted as data, not a bubble (SHL 0x6BE3)
        step(0, 1, 16'h6BE3, 0, 0);
        chk("shl.pending", 32'(imm_pending), 32'd1);
        step(0, 1, 16'h0000, 0, 0);
        chk_op("shl.zimm", 5'd13, 3'd3, 3'd7, 5'd3, 16'h0000, 1'b1, 1'b0);

        // INT (0x4000), POP (0x4800), LDD (0x5000) are one-word ops
        step(0, 1, 16'h4000, 0, 0);
        chk_op("int", 5'd8, 3'd0, 3'd0, 5'd0, 16'h0, 1'b1, 1'b0);
        step(0, 1, 16'h4ABC, 0, 0);
        chk_op("pop", 5'd9, 3'd2, 3'd5, 5'd28, 16'h0, 1'b1, 1'b0);
        step(0, 1, 16'h5000, 0, 0);
        chk_op("ldd", 5'd10, 3'd0, 3'd0, 5'd0, 16'h0, 1'b1, 1'b0);

        // Reset in S_WAIT_IMM clears everything; next word is a fresh opcode
        step(0, 1, 16'h6120, 0, 0);
        step(1, 1, 16'h00FF, 0, 0);
        chk_op("rstwait", 5'd0, 3'd0, 3'd0, 5'd0, 16'h0, 1'b0, 1'b0);
        step(0, 1, 16'h2A65, 0, 0);
        chk_op("rstwait.next", 5'd5, 3'd2, 3'd3, 5'd5, 16'h0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
